io_arb_rr: RTL
==============

// Module: io_arb_rr
// PURPOSE
//  Parametrised successor to the single-debugger I/O arbiter. Shares the core's 6-bit I/O bus
//  between the AVR core (absolute priority, zero-latency pass-through) and NCH secondary masters
//  (debugger, DMA, ...). Secondary masters arbitrate round-robin through a registered
//  req/ack handshake. Read data is captured, and a deferral timeout guards against starvation.
//  Sits between the core/secondary masters and the I/O peripheral bus.
// PARAMETERS
//  NCH        2   number of secondary masters (1..8)
//  ADR_W      6   I/O address width
//  DW         8   data width
//  MAX_DEFER  16  max cycles a granted access may be held off by the core; 0 = no timeout
// PORTS
//  cp2        in   1          clock; all state updates on the rising edge
//  rst        in   1          asynchronous reset, active-high
//  c_adr      in   ADR_W      core I/O address
//  c_iore     in   1          core I/O read strobe
//  c_iowe     in   1          core I/O write strobe
//  c_ramre    in   1          core RAM read strobe (marks the core as busy)
//  c_ramwe    in   1          core RAM write strobe (marks the core as busy)
//  c_dbusout  in   DW         core write data
//  s_req      in   NCH        per-master request; held high until s_ack or s_err
//  s_we       in   NCH        per-master: 1 = write, 0 = read
//  s_adr      in   NCH*ADR_W  per-master address; channel i occupies [i*ADR_W +: ADR_W]
//  s_wdata    in   NCH*DW     per-master write data; channel i occupies [i*DW +: DW]
//  s_ack      out  NCH        one-cycle completion pulse, registered
//  s_err      out  NCH        one-cycle timeout pulse, registered; s_ack stays 0
//  s_wait     out  NCH        s_req[i] & ~s_ack[i] & ~s_err[i]
//  s_rdata    out  DW         captured read data; valid while s_ack is high, held afterwards
//  dbusin     in   DW         read data returned from the I/O peripherals
//  adr        out  ADR_W      I/O bus address
//  iore       out  1          I/O bus read strobe
//  iowe       out  1          I/O bus write strobe
//  dbusout    out  DW         I/O bus write data
// BEHAVIOUR
//  - core_busy = c_iore|c_iowe|c_ramre|c_ramwe.
//  - While core_busy, the bus outputs follow the core combinationally in every state:
//    adr=c_adr, iore=c_iore, iowe=c_iowe, dbusout=c_dbusout.
//  - Reset values: state=IDLE, ptr=NCH-1, gnt=0, defer_cnt=0, s_ack=0, s_err=0, s_rdata=0.
//    The bus outputs are 0 unless the core is busy.
//  - FSM, 2 states:
//    IDLE: elig = s_req & ~s_ack & ~s_err. If elig != 0, pick the first set bit searching from
//      ptr+1 upward, wrapping modulo NCH. Latch gnt, we, adr and wdata; go to ACC.
//      Bus stays 0 unless the core is busy.
//    ACC, core_busy: the bus belongs to the core. defer_cnt++. If MAX_DEFER != 0 and
//      defer_cnt == MAX_DEFER-1: s_err[gnt] <= 1, ptr <= gnt, go to IDLE.
//    ACC, core idle: drive the latched access (adr, dbusout, iowe=we, iore=~we) for exactly
//      one cycle. At the edge: s_ack[gnt] <= 1; on a read, s_rdata <= dbusin.
//      ptr <= gnt, defer_cnt <= 0, go to IDLE.
//  - Best-case latency: req sampled in cycle 0, bus access in cycle 1, s_ack and s_rdata in cycle 2.
//  - Re-grant masking: a master whose ack/err is high cannot be granted in that cycle. The
//    requester must drop s_req in the ack cycle.
//  - Round-robin: the master just served becomes lowest priority. With NCH=1 the search is
//    trivial and the master is granted every other cycle at most.
//  - s_req falling while in ACC: the latched access still completes (no cancellation).
//  - rst asserted mid-access: state and outputs return to reset values at once; no ack or err
//    is issued for the aborted access.
//  - defer_cnt width = clog2(MAX_DEFER+1); it saturates and never wraps.
// STRUCTURE
//  - Shared include io_arb_pkg.vh: state encodings (ST_IDLE, ST_ACC) and the clog2 function.
//  - One sub-module, rr_pick: combinational round-robin priority picker with inputs
//    (elig[NCH], ptr) and outputs (gnt_idx, any). The FSM, latches and bus mux stay in this file.
// TESTING
//  - Single read: NCH=2; s_req[0]=1, s_we[0]=0, s_adr[0]=6'h3F; dbusin=8'hA5.
//    Expect iore=1, adr=3F in cycle 1; s_ack=2'b01 and s_rdata=A5 in cycle 2.
//  - Round-robin: s_req=2'b11 held, dropping each bit in its ack cycle then re-raising it.
//    Expect grant order 0,1,0,1; acks never on consecutive cycles.
//  - Core preemption: in ACC for ch1 (write 8'h5C to 6'h12), hold c_iowe=1, c_adr=6'h01 for 3 cycles.
//    Expect the bus to show the core access for those 3 cycles. Then one cycle with adr=12,
//    dbusout=5C, iowe=1, then s_ack[1].
//  - Timeout: MAX_DEFER=4, hold c_ramre=1 during ACC.
//    Expect s_err[gnt] pulse after 4 deferred cycles, s_ack=0, no secondary strobe ever driven.
//  - Reset mid-op: assert rst while the ACC strobe is active.
//    Expect iore/iowe/s_ack=0 immediately; after release, ch0 is granted first.
//  - Simultaneous: the core starts c_iore in the same cycle the FSM enters ACC.
//    Expect the core to win, the secondary strobe to be delayed, and the read data to match the later cycle.

Source files
------------

// File: rtl/io_arb_rr_pkg.sv
// Shared definitions for the round-robin I/O bus arbiter: FSM state
// encoding and width helpers used to size indices and counters.
package io_arb_rr_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } state_t;

   // Ceiling log2 for positive values; clog2(1) = 0.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         res++;
      end
      return res;
   endfunction

   // Bit width needed to hold values 0..n-1, never narrower than one bit.
   function automatic int width_of(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/io_arb_rr_rr_pick.sv
// Combinational round-robin picker: returns the eligible channel nearest
// above ptr, wrapping modulo NCH, so the channel at ptr ranks last.
module rr_pick
   import io_arb_rr_pkg::*;
#(
   parameter int NCH = 2,
   parameter int IW  = 1
) (
   input  logic [NCH-1:0] elig,
   input  logic [IW-1:0]  ptr,
   output logic [IW-1:0]  gnt_idx,
   output logic           any
);

   int best;

   // Pick the eligible channel with the smallest wrap distance past ptr.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      gnt_idx = '0;
      any     = 1'b0;
      best    = NCH;
      for (int i = 0; i < NCH; i++) begin
         if (elig[i] && (((i + 2 * NCH - int'(ptr) - 1) % NCH) < best)) begin
            best    = (i + 2 * NCH - int'(ptr) - 1) % NCH;
            gnt_idx = IW'(i);
            any     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/io_arb_rr.sv
// I/O bus arbiter: the AVR core owns the bus combinationally whenever it is
// busy; NCH secondary masters share the remaining cycles round-robin via a
// registered req/ack handshake with a deferral timeout.
module io_arb_rr
   import io_arb_rr_pkg::*;
#(
   parameter int NCH       = 2,
   parameter int ADR_W     = 6,
   parameter int DW        = 8,
   parameter int MAX_DEFER = 16
) (
   input  logic                 cp2,
   input  logic                 rst,
   input  logic [ADR_W-1:0]     c_adr,
   input  logic                 c_iore,
   input  logic                 c_iowe,
   input  logic                 c_ramre,
   input  logic                 c_ramwe,
   input  logic [DW-1:0]        c_dbusout,
   input  logic [NCH-1:0]       s_req,
   input  logic [NCH-1:0]       s_we,
   input  logic [NCH*ADR_W-1:0] s_adr,
   input  logic [NCH*DW-1:0]    s_wdata,
   output logic [NCH-1:0]       s_ack,
   output logic [NCH-1:0]       s_err,
   output logic [NCH-1:0]       s_wait,
   output logic [DW-1:0]        s_rdata,
   input  logic [DW-1:0]        dbusin,
   output logic [ADR_W-1:0]     adr,
   output logic                 iore,
   output logic                 iowe,
   output logic [DW-1:0]        dbusout
);

   localparam int IW = width_of(NCH);
   localparam int CW = width_of(MAX_DEFER + 1);
   localparam logic [CW-1:0] DEFER_MAX  = CW'(MAX_DEFER);
   localparam logic [CW-1:0] DEFER_LAST = CW'((MAX_DEFER == 0) ? 0 : MAX_DEFER - 1);

   state_t             state;
   logic [IW-1:0]      ptr;
   logic [IW-1:0]      gnt;
   logic               lat_we;
   logic [ADR_W-1:0]   lat_adr;
   logic [DW-1:0]      lat_wdata;
   logic [CW-1:0]      defer_cnt;

   logic               core_busy;
   logic [NCH-1:0]     elig;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;
   logic               sel_we;
   logic [ADR_W-1:0]   sel_adr;
   logic [DW-1:0]      sel_wdata;
   logic [NCH-1:0]     gnt_1h;

   assign core_busy = c_iore | c_iowe | c_ramre | c_ramwe;
   assign elig      = s_req & ~s_ack & ~s_err;
   assign s_wait    = s_req & ~s_ack & ~s_err;

   rr_pick #(
      .NCH (NCH),
      .IW  (IW)
   ) u_pick (
      .elig    (elig),
      .ptr     (ptr),
      .gnt_idx (pick_idx),
      .any     (pick_any)
   );

   // Select the picked channel's request fields and decode the held grant.
   always_comb begin
      sel_we    = 1'b0;
      sel_adr   = '0;
      sel_wdata = '0;
      gnt_1h    = '0;
      for (int i = 0; i < NCH; i++) begin
         if (pick_idx == IW'(i)) begin
            sel_we    = s_we[i];
            sel_adr   = s_adr[i*ADR_W +: ADR_W];
            sel_wdata = s_wdata[i*DW +: DW];
         end
         gnt_1h[i] = (gnt == IW'(i));
      end
   end

   // Bus mux: core pass-through beats the latched secondary access.
   always_comb begin
      adr     = '0;
      iore    = 1'b0;
      iowe    = 1'b0;
      dbusout = '0;
      if (core_busy) begin
         adr     = c_adr;
         iore    = c_iore;
         iowe    = c_iowe;
         dbusout = c_dbusout;
      end else if (state == ST_ACC) begin
         adr     = lat_adr;
         iore    = ~lat_we;
         iowe    = lat_we;
         dbusout = lat_wdata;
      end
   end

   // Arbitration FSM with registered ack/err pulses and read-data capture.
   always_ff @(posedge cp2 or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= IW'(NCH - 1);
         gnt       <= '0;
         lat_we    <= 1'b0;
         lat_adr   <= '0;
         lat_wdata <= '0;
         defer_cnt <= '0;
         s_ack     <= '0;
         s_err     <= '0;
         s_rdata   <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
         s_ack <= '0;
         s_err <= '0;
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  gnt       <= pick_idx;
                  lat_we    <= sel_we;
                  lat_adr   <= sel_adr;
                  lat_wdata <= sel_wdata;
                  defer_cnt <= '0;
                  state     <= ST_ACC;
               end
            end
            ST_ACC: begin
               if (core_busy) begin
                  if (defer_cnt != DEFER_MAX) begin
                     defer_cnt <= defer_cnt + CW'(1);
                  end
                  if (MAX_DEFER != 0 && defer_cnt == DEFER_LAST) begin
                     s_err     <= gnt_1h;
                     ptr       <= gnt;
                     defer_cnt <= '0;
                     state     <= ST_IDLE;
                  end
               end else begin
                  s_ack <= gnt_1h;
                  if (!lat_we) begin
                     s_rdata <= dbusin;
                  end
                  ptr       <= gnt;
                  defer_cnt <= '0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
